// File: rtl/ser_word_assembler_pkg.sv
// ============================================================================
// Package     : ser_pkg
// Description : Shared definitions for the serial word assembler: FSM state
//               encodings and a width helper for the bit/idle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Bits needed to hold values 0..max_val; never less than one bit so a
  // disabled counter (max_val = 0) still has a legal declaration.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_word_assembler_shift.sv
// ============================================================================
// Module      : shift_in_reg
// Description : Serial-in shift storage. Shifts one bit per enabled cycle,
//               either toward the MSB (first bit ends in SIZE-1) or toward
//               the LSB (first bit ends in bit 0).
// Ports       : clk      - rising-edge clock
//               rst_n    - synchronous active-low reset
//               clear    - synchronous clear of the stored word
//               shift_en - shift sin into the word this cycle
//               sin      - serial data in
//               word     - stored word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_in_reg
  import ser_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            shift_en,
  input  logic            sin,
  output logic [SIZE-1:0] word
);

  logic [SIZE-1:0] word_shifted;

  if (MSB_FIRST) begin : g_msb_first
    assign word_shifted = {word[SIZE-2:0], sin};
  end else begin : g_lsb_first
    assign word_shifted = {sin, word[SIZE-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= word_shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ser_word_assembler.sv
// ============================================================================
// Module      : ser_word_assembler
// Description : Collects a serial bit stream into a SIZE-bit word and drives
//               a parallel-load register: one load pulse with the word on
//               completion, a load+clr pulse on abort or idle timeout.
// Ports       : clk, rst_n (sync active-low)
//               frame_start, sdata, bit_valid, abort - serial side inputs
//               d, load, clr    - downstream register controls (registered)
//               busy            - high while a frame is being shifted
//               frame_err       - sticky error (abort/timeout/restart)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_word_assembler
  import ser_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            sdata,
  input  logic            bit_valid,
  input  logic            abort,
  output logic [SIZE-1:0] d,
  output logic            load,
  output logic            clr,
  output logic            busy,
  output logic            frame_err
);

  localparam int BCW = cnt_width(SIZE);
  localparam int ICW = cnt_width(TIMEOUT);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(SIZE - 1);
  // Timeout fires on the TIMEOUT-th idle cycle, i.e. when TIMEOUT-1 idle
  // cycles have already been counted and this one is idle too.
  localparam logic [ICW-1:0] IDLE_LIMIT = ICW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic            state, state_nxt;
  logic [BCW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [ICW-1:0]  idle_cnt, idle_cnt_nxt;
  logic            sr_clear, sr_shift;
  logic [SIZE-1:0] word, word_done;
  logic            timeout_hit;
  logic            ev_load, ev_fail, ev_start, ev_restart;
  logic [SIZE-1:0] d_nxt;
  logic            load_nxt, clr_nxt, err_nxt;

  shift_in_reg #(
    .SIZE      (SIZE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .sin      (sdata),
    .word     (word)
  );

  // The word as it will look once this cycle's bit is shifted in; captured
  // into d on the completing edge so load and d appear together.
  if (MSB_FIRST) begin : g_done_msb
    assign word_done = {word[SIZE-2:0], sdata};
  end else begin : g_done_lsb
    assign word_done = {sdata, word[SIZE-1:1]};
  end

  // State and counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Next-state logic; priority abort > timeout > frame_start > bit_valid
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    idle_cnt_nxt = idle_cnt;
    sr_clear     = 1'b0;
    sr_shift     = 1'b0;
    ev_load      = 1'b0;
    ev_fail      = 1'b0;
    ev_start     = 1'b0;
    ev_restart   = 1'b0;
    timeout_hit  = (TIMEOUT > 0) && !bit_valid && (idle_cnt == IDLE_LIMIT);
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt    = ST_SHIFT;
          sr_clear     = 1'b1;
          bit_cnt_nxt  = '0;
          idle_cnt_nxt = '0;
          ev_start     = 1'b1;
        end
      end
      default: begin
        if (abort || timeout_hit) begin
          state_nxt    = ST_IDLE;
          bit_cnt_nxt  = '0;
          idle_cnt_nxt = '0;
          ev_fail      = 1'b1;
        end else if (frame_start) begin
          sr_clear     = 1'b1;
          bit_cnt_nxt  = '0;
          idle_cnt_nxt = '0;
          ev_restart   = 1'b1;
        end else if (bit_valid) begin
          sr_shift     = 1'b1;
          idle_cnt_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            ev_load     = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else if (TIMEOUT > 0) begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end
    endcase
  end

  // Output decode
  always_comb begin
    d_nxt    = d;
    load_nxt = 1'b0;
    clr_nxt  = 1'b0;
    err_nxt  = frame_err;
    if (ev_load) begin
      d_nxt    = word_done;
      load_nxt = 1'b1;
    end
    if (ev_fail) begin
      d_nxt    = '0;
      load_nxt = 1'b1;
      clr_nxt  = 1'b1;
      err_nxt  = 1'b1;
    end
    if (ev_restart) begin
      err_nxt = 1'b1;
    end
    if (ev_start) begin
      err_nxt = 1'b0;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d         <= '0;
      load      <= 1'b0;
      clr       <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      d         <= d_nxt;
      load      <= load_nxt;
      clr       <= clr_nxt;
      busy      <= (state_nxt == ST_SHIFT);
      frame_err <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ser_word_assembler.sv
// ============================================================================
// Module      : tb_ser_word_assembler
// Description : Self-checking bench for ser_word_assembler. Two instances
//               (MSB-first and LSB-first, TIMEOUT=16) share one stimulus
//               stream and are compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_word_assembler;

  localparam int SIZE = 8;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic sdata = 1'b0;
  logic bit_valid = 1'b0;
  logic abort = 1'b0;

  logic [SIZE-1:0] d_m, d_l;
  logic load_m, clr_m, busy_m, err_m;
  logic load_l, clr_l, busy_l, err_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ser_word_assembler #(.SIZE(SIZE), .MSB_FIRST(1'b1), .TIMEOUT(TO)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdata(sdata),
    .bit_valid(bit_valid), .abort(abort), .d(d_m), .load(load_m),
    .clr(clr_m), .busy(busy_m), .frame_err(err_m)
  );

  ser_word_assembler #(.SIZE(SIZE), .MSB_FIRST(1'b0), .TIMEOUT(TO)) dut_l (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sdata(sdata),
    .bit_valid(bit_valid), .abort(abort), .d(d_l), .load(load_l),
    .clr(clr_l), .busy(busy_l), .frame_err(err_l)
  );

  // Frame-level reference model
  bit       m_in = 1'b0;
  int       m_bits[$];
  int       m_idle = 0;
  int       m_d_m = 0;
  int       m_d_l = 0;
  bit       m_load = 1'b0;
  bit       m_clr = 1'b0;
  bit       m_busy = 1'b0;
  bit       m_err = 1'b0;

  typedef struct {
    logic fs, sd, bv, ab, rn;
    logic e_load, e_clr, e_busy, e_err;
    logic [7:0] e_d;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic fs, sd, bv, ab, rn,
                              input logic e_load, e_clr, e_busy, e_err,
                              input logic [7:0] e_d);
    vec_t v;
    v.fs = fs; v.sd = sd; v.bv = bv; v.ab = ab; v.rn = rn;
    v.e_load = e_load; v.e_clr = e_clr; v.e_busy = e_busy; v.e_err = e_err;
    v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic fs, sd, bv, ab, rn);
    int wm, wl;
    if (!rn) begin
      m_in = 1'b0; m_bits.delete(); m_idle = 0;
      m_d_m = 0; m_d_l = 0; m_load = 1'b0; m_clr = 1'b0; m_err = 1'b0;
    end else begin
      m_load = 1'b0;
      m_clr  = 1'b0;
      if (!m_in) begin
        if (fs) begin
          m_in = 1'b1; m_bits.delete(); m_idle = 0; m_err = 1'b0;
        end
      end else if (ab || (!bv && (m_idle + 1 == TO))) begin
        m_in = 1'b0; m_load = 1'b1; m_clr = 1'b1;
        m_d_m = 0; m_d_l = 0; m_err = 1'b1;
      end else if (fs) begin
        m_bits.delete(); m_idle = 0; m_err = 1'b1;
      end else if (bv) begin
        m_bits.push_back(int'(sd));
        m_idle = 0;
        if (m_bits.size() == SIZE) begin
          wm = 0; wl = 0;
          for (int i = 0; i < SIZE; i++) begin
            wm += m_bits[i] * (1 << (SIZE - 1 - i));
            wl += m_bits[i] * (1 << i);
          end
          m_d_m = wm; m_d_l = wl;
          m_load = 1'b1; m_in = 1'b0;
        end
      end else begin
        m_idle++;
      end
    end
    m_busy = m_in;
  endtask

  task automatic step(input logic fs, sd, bv, ab, rn, input bit cmp);
    @(negedge clk);
    frame_start = fs; sdata = sd; bit_valid = bv; abort = ab; rst_n = rn;
    @(posedge clk);
    model_step(fs, sd, bv, ab, rn);
    #1;
    if (cmp) begin
      chk("d_msb",    32'(d_m),    32'(m_d_m));
      chk("d_lsb",    32'(d_l),    32'(m_d_l));
      chk("load_msb", 32'(load_m), 32'(m_load));
      chk("load_lsb", 32'(load_l), 32'(m_load));
      chk("clr_msb",  32'(clr_m),  32'(m_clr));
      chk("clr_lsb",  32'(clr_l),  32'(m_clr));
      chk("busy_msb", 32'(busy_m), 32'(m_busy));
      chk("busy_lsb", 32'(busy_l), 32'(m_busy));
      chk("err_msb",  32'(err_m),  32'(m_err));
      chk("err_lsb",  32'(err_l),  32'(m_err));
    end
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic start_frame();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Send bits seq[7-first] .. seq[7-(first+n-1)], with gap idle cycles
  // between consecutive bits.
  task automatic send_seq(input logic [7:0] seq, input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      if (i > first && gap > 0) idle_n(gap);
      step(1'b0, seq[7-i], 1'b1, 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a5;
    int bvp;
    a5 = 8'hA5;

    // Reset then a clean MSB-first A5 frame (A5 is a bit palindrome, so
    // both instances must produce the same word)
    vecs[0] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 8'h00);
    vecs[1] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[2] = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 7; i++)
      vecs[3+i] = mk(0, a5[7-i], 1, 0, 1, 0, 0, 1, 0, 8'h00);
    vecs[10] = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 8'hA5);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 8'hA5);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].fs, vecs[i].sd, vecs[i].bv, vecs[i].ab, vecs[i].rn, 1'b0);
      chk($sformatf("vec%0d_load_m", i), 32'(load_m), 32'(vecs[i].e_load));
      chk($sformatf("vec%0d_load_l", i), 32'(load_l), 32'(vecs[i].e_load));
      chk($sformatf("vec%0d_clr", i),    32'(clr_m),  32'(vecs[i].e_clr));
      chk($sformatf("vec%0d_busy", i),   32'(busy_m), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i),    32'(err_m),  32'(vecs[i].e_err));
      chk($sformatf("vec%0d_d_m", i),    32'(d_m),    32'(vecs[i].e_d));
      chk($sformatf("vec%0d_d_l", i),    32'(d_l),    32'(vecs[i].e_d));
    end

    // Gapped frames (3 idle cycles between bits)
    start_frame();
    send_seq(8'hA5, 0, 8, 3);
    chk("gap_a5_lsb", 32'(d_l), 32'h A5);
    chk("gap_a5_load", 32'(load_l), 32'h1);
    start_frame();
    send_seq(8'hC0, 0, 8, 3);
    chk("gap_03_lsb", 32'(d_l), 32'h03);
    chk("gap_c0_msb", 32'(d_m), 32'hC0);

    // Abort after 5 bits, then recovery
    start_frame();
    send_seq(8'h5B, 0, 5, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_load", 32'(load_m), 32'h1);
    chk("abort_clr",  32'(clr_m),  32'h1);
    chk("abort_d",    32'(d_m),    32'h0);
    chk("abort_err",  32'(err_m),  32'h1);
    idle_n(1);
    chk("abort_err_hold", 32'(err_m), 32'h1);
    chk("abort_one_pulse", 32'(load_m), 32'h0);
    start_frame();
    chk("abort_err_clear", 32'(err_m), 32'h0);
    send_seq(8'h5B, 0, 8, 0);
    chk("recover_d_msb", 32'(d_m), 32'h5B);
    chk("recover_d_lsb", 32'(d_l), 32'hDA);
    chk("recover_clr",   32'(clr_m), 32'h0);

    // Timeout: 16th idle cycle aborts, 15 idle cycles do not
    start_frame();
    send_seq(8'h96, 0, 3, 0);
    idle_n(15);
    chk("to_not_yet_load", 32'(load_m), 32'h0);
    chk("to_not_yet_busy", 32'(busy_m), 32'h1);
    idle_n(1);
    chk("to_load", 32'(load_m), 32'h1);
    chk("to_clr",  32'(clr_m),  32'h1);
    chk("to_err",  32'(err_m),  32'h1);
    chk("to_busy", 32'(busy_m), 32'h0);
    start_frame();
    send_seq(8'h96, 0, 3, 0);
    idle_n(15);
    send_seq(8'h96, 3, 5, 0);
    chk("to15_load", 32'(load_m), 32'h1);
    chk("to15_clr",  32'(clr_m),  32'h0);
    chk("to15_d",    32'(d_m),    32'h96);

    // Abort on the same cycle as the 8th bit
    start_frame();
    send_seq(8'hFF, 0, 7, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort8_load", 32'(load_m), 32'h1);
    chk("abort8_clr",  32'(clr_m),  32'h1);
    chk("abort8_d",    32'(d_m),    32'h0);

    // Restart mid-frame
    start_frame();
    send_seq(8'hF0, 0, 4, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("restart_err",  32'(err_m),  32'h1);
    chk("restart_busy", 32'(busy_m), 32'h1);
    chk("restart_load", 32'(load_m), 32'h0);
    send_seq(8'h3C, 0, 7, 0);
    chk("restart_7_load", 32'(load_m), 32'h0);
    send_seq(8'h3C, 7, 1, 0);
    chk("restart_8_load", 32'(load_m), 32'h1);
    chk("restart_8_d",    32'(d_m),    32'h3C);

    // Reset mid-frame
    start_frame();
    send_seq(8'hFF, 0, 4, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_load", 32'(load_m), 32'h0);
    chk("rst_mid_busy", 32'(busy_m), 32'h0);
    send_seq(8'hFF, 0, 8, 0);
    chk("rst_idle_bits_load", 32'(load_m), 32'h0);

    // Randomized traffic against the model
    bvp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 2))
          0: bvp = 4;
          1: bvp = 50;
          default: bvp = 90;
        endcase
      end
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < bvp), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 299) != 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ser_word_assembler.md
Name: ser_word_assembler

Overview:
- Upstream feeder for the parallel-load register. Collects a serial bit stream into a SIZE-bit word.
- Drives that register's d/load/clr inputs: a one-cycle load pulse with the word on completion, and a load+clr pulse on abort or timeout.
- Sits between a serial input front-end (e.g. a switch/debounced data line or an SPI-like source) and the parallel-load register.

Parameters:
- SIZE, 8, word width in bits; the number of valid bits per frame.
- MSB_FIRST, 1, 1 = first received bit lands in bit SIZE-1; 0 = first bit lands in bit 0.
- TIMEOUT, 16, maximum consecutive idle cycles (no bit_valid) while shifting before an abort; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- frame_start  input  1  begins a new frame (level sampled each cycle).
- sdata  input  1  serial data bit.
- bit_valid  input  1  sdata is valid this cycle.
- abort  input  1  cancels the frame in progress.
- d  output  SIZE  assembled word, connects to the downstream register's d.
- load  output  1  one-cycle strobe to the downstream register.
- clr  output  1  qualifies load as a clear; asserted only together with load.
- busy  output  1  high while in SHIFT.
- frame_err  output  1  sticky error flag.

Behaviour:
- Reset: rst_n=0 at a clk edge forces the following, all synchronous:
  - state=IDLE; shift register, bit count and idle count = 0.
  - d=0, load=0, clr=0, busy=0, frame_err=0.
  - Reset mid-frame discards partial data with no load pulse.
- All outputs are registered.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - frame_start=1 → SHIFT next cycle. Clear the shift register, bit count, idle count and frame_err.
  - A bit_valid in the same cycle as frame_start is ignored.
  - Otherwise the FSM stays in IDLE.
- SHIFT, bit handling:
  - busy=1.
  - Each cycle with bit_valid=1 shifts sdata into the shift register (direction per MSB_FIRST), increments the bit count and clears the idle count.
- SHIFT, completion:
  - On the cycle the SIZE-th valid bit is sampled, the FSM returns to IDLE.
  - The next cycle has d = assembled word, load=1, clr=0 for exactly one cycle.
  - Latency: load is high in the cycle after the last bit is sampled. Downstream q updates on the edge ending that cycle.
- SHIFT, abort, timeout and restart:
  - Abort: abort=1 → IDLE. Next cycle has load=1, clr=1 and d=0 for one cycle, and frame_err=1.
  - Timeout: TIMEOUT>0 and the idle count reaches TIMEOUT (TIMEOUT consecutive cycles without bit_valid) → same response as abort.
  - Restart: frame_start=1 without abort → restart. Bit count and shift register clear, frame_err=1, no load pulse, stay in SHIFT.
- Priority within one cycle: rst_n > abort > timeout > frame_start > bit_valid.
  - An abort arriving on the same cycle as the SIZE-th bit wins: clear, not load.
- Hold conditions:
  - abort in IDLE: no effect.
  - d holds its last value outside load cycles.
  - frame_err holds until the next accepted frame_start from IDLE, or reset.
- A frame_start during the load cycle is accepted normally. Back-to-back frames lose no bits after that start cycle.
- The bit count is sized to $clog2(SIZE+1) and never wraps past SIZE.

Decomposition:
- Shared package ser_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - a width helper function for the counters.
- One sub-module, shift_in_reg #(SIZE, MSB_FIRST): inputs clk, rst_n, clear, shift_en, sin; output word. It is pure shift storage; the top holds the FSM, counters and output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs → d=0, load=0, clr=0, busy=0, frame_err=0 throughout and after.
- Normal MSB-first frame: SIZE=8, MSB_FIRST=1, frame_start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles → exactly one load pulse, the cycle after the 8th bit; d=8'hA5, clr=0, busy falls with it.
- Gapped LSB-first frame: MSB_FIRST=0, same bit sequence with 3-cycle gaps (below TIMEOUT) → d=8'hA5 reversed = 8'hA5 (palindrome check). Repeat with bits 1,1,0,0,0,0,0,0 → d=8'h03.
- Abort: abort after 5 bits → one cycle load=1, clr=1, d=0; frame_err=1. The next frame_start clears frame_err, and a full frame loads correctly.
- Timeout: TIMEOUT=16, 3 bits then 16 idle cycles → load=1, clr=1 in the cycle after the 16th idle cycle; frame_err=1. With 15 idle cycles then the remaining bits → normal load.
- Collisions:
  - abort coincident with the 8th bit → clear, no data load.
  - frame_start mid-frame → restart, frame_err=1, no load until 8 fresh bits.
  - rst_n low mid-frame → no load pulse.
